register_bank_alu: RTL and testbench

REGISTER_BANK_ALU -- requirements
Module: register_bank_alu

---
 rtl/register_bank_alu_pkg.sv | 20 ++
 rtl/register_bank_alu_core.sv | 46 ++++
 rtl/register_bank_alu.sv | 122 ++++++++++++
 tb/tb_register_bank_alu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_alu_pkg.sv
// Shared encodings and default sizing for the register bank / ALU block.
package register_bank_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREG  = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CMP  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/register_bank_alu_core.sv
// Combinational ALU datapath: add/subtract/pass with carry, zero, negative
// and unsigned greater-than flags.
module reg_alu_core
    import register_bank_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] res,
    output logic             cy,
    output logic             z,
    output logic             ng,
    output logic             gt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit of the widened difference is the borrow (a < b).
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res  = '0;
        cy   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                res = diff[WIDTH-1:0];
                cy  = diff[WIDTH];
            end
            default: begin
                res = a;
                cy  = 1'b0;
            end
        endcase
        z  = (res == '0);
        ng = res[WIDTH-1];
        gt = (a > b);
    end

endmodule

// File: rtl/register_bank_alu.sv
// Register bank on a shared tri-state bus with a three-state sequencer that
// runs one ALU operation per start request and writes the result back.
module register_bank_alu
    import register_bank_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREG  = DEFAULT_NREG,
    localparam int SW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          clr,
    inout  wire [WIDTH-1:0] w,
    input  logic          ld,
    input  logic [SW-1:0] ld_sel,
    input  logic          oe,
    input  logic [SW-1:0] oe_sel,
    input  logic          eu,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [SW-1:0] src_a,
    input  logic [SW-1:0] src_b,
    input  logic [SW-1:0] dst,
    output logic          busy,
    output logic          done,
    output logic          cy,
    output logic          z,
    output logic          ng,
    output logic          gt
);

    state_e           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    op_e              op_lat;
    logic [SW-1:0]    dst_lat;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             alu_z;
    logic             alu_ng;
    logic             alu_gt;
    logic             wb_en;

    reg_alu_core #(.WIDTH(WIDTH)) u_core (
        .a   (a_lat),
        .b   (b_lat),
        .op  (op_lat),
        .res (alu_res),
        .cy  (alu_cy),
        .z   (alu_z),
        .ng  (alu_ng),
        .gt  (alu_gt)
    );

    assign wb_en = (state == ST_EXEC) && (op_lat != OP_CMP);
    assign busy  = (state != ST_IDLE);

    // Result register has priority over register readout; bus floats in reset.
    assign w = (clr && eu) ? res_reg :
               (clr && oe) ? regs[oe_sel] : 'z;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            a_lat   <= '0;
            b_lat   <= '0;
            op_lat  <= OP_ADD;
            dst_lat <= '0;
            res_reg <= '0;
            cy      <= 1'b0;
            z       <= 1'b0;
            ng      <= 1'b0;
            gt      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_lat   <= regs[src_a];
                        b_lat   <= regs[src_b];
                        op_lat  <= op_e'(op);
                        dst_lat <= dst;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_lat != OP_CMP) begin
                        res_reg <= alu_res;
                    end
                    cy    <= alu_cy;
                    z     <= alu_z;
                    ng    <= alu_ng;
                    gt    <= alu_gt;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A bus load to the same register as the writeback takes precedence.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (ld && (ld_sel == SW'(i))) begin
                    regs[i] <= w;
                end else if (wb_en && (dst_lat == SW'(i))) begin
                    regs[i] <= alu_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_bank_alu.sv
// Scoreboard bench for register_bank_alu: default 8-bit/4-register instance
// plus a 16-bit/8-register instance.
module tb_register_bank_alu;
    import register_bank_alu_pkg::*;

    localparam int W  = 8;
    localparam int W2 = 16;

    typedef struct packed {
        logic cy;
        logic z;
        logic ng;
        logic gt;
    } flags_t;

    logic clk = 1'b0;
    logic clr = 1'b0;

    wire  [W-1:0] w;
    logic [W-1:0] drv = '0;
    logic         drv_en = 1'b0;
    logic         ld = 0, oe = 0, eu = 0, start = 0;
    logic [1:0]   ld_sel = 0, oe_sel = 0, src_a = 0, src_b = 0, dst = 0;
    logic [1:0]   op = 0;
    logic         busy, done, cy, z, ng, gt;

    wire  [W2-1:0] b_w;
    logic [W2-1:0] b_drv = '0;
    logic          b_drv_en = 1'b0;
    logic          b_ld = 0, b_oe = 0, b_eu = 0, b_start = 0;
    logic [2:0]    b_ld_sel = 0, b_oe_sel = 0, b_src_a = 0, b_src_b = 0, b_dst = 0;
    logic [1:0]    b_op = 0;
    logic          b_busy, b_done, b_cy, b_z, b_ng, b_gt;

    int     checks = 0;
    int     errors = 0;
    int     done_count = 0;
    flags_t exp_q[$];
    time    done_times[$];
    flags_t mon_exp;

    always #5 clk = ~clk;

    // Undriven bus bits read as ones so a floating bus is observable.
    assign w   = drv_en ? drv : 'z;
    assign b_w = b_drv_en ? b_drv : 'z;
    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup (w[i]);
    end
    for (genvar i = 0; i < W2; i++) begin : g_pu2
        pullup (b_w[i]);
    end

    register_bank_alu dut (
        .clk(clk), .clr(clr), .w(w), .ld(ld), .ld_sel(ld_sel), .oe(oe),
        .oe_sel(oe_sel), .eu(eu), .start(start), .op(op), .src_a(src_a),
        .src_b(src_b), .dst(dst), .busy(busy), .done(done), .cy(cy), .z(z),
        .ng(ng), .gt(gt)
    );

    register_bank_alu #(.WIDTH(W2), .NREG(8)) dut16 (
        .clk(clk), .clr(clr), .w(b_w), .ld(b_ld), .ld_sel(b_ld_sel), .oe(b_oe),
        .oe_sel(b_oe_sel), .eu(b_eu), .start(b_start), .op(b_op), .src_a(b_src_a),
        .src_b(b_src_b), .dst(b_dst), .busy(b_busy), .done(b_done), .cy(b_cy),
        .z(b_z), .ng(b_ng), .gt(b_gt)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every completion pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            done_times.push_back($time);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("flags", {28'd0, cy, z, ng, gt}, {28'd0, mon_exp});
            end
        end
    end

    task automatic load_reg(input logic [1:0] idx, input logic [W-1:0] val);
        @(negedge clk);
        drv_en = 1; drv = val; ld = 1; ld_sel = idx;
        @(negedge clk);
        drv_en = 0; ld = 0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] idx, input logic [W-1:0] exp);
        @(negedge clk);
        oe = 1; oe_sel = idx;
        #1 check_output(name, {24'd0, w}, {24'd0, exp});
        oe = 0;
    endtask

    task automatic read_res(input string name, input logic [W-1:0] exp);
        @(negedge clk);
        eu = 1; oe = 1; oe_sel = 0;
        #1 check_output(name, {24'd0, w}, {24'd0, exp});
        eu = 0; oe = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 8 && busy; i++) @(negedge clk);
        check_output({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic apply_stimulus(input string name, input op_e o, input logic [1:0] a,
                                  input logic [1:0] b, input logic [1:0] d, input flags_t exp,
                                  input bit mid_ld, input logic [1:0] mid_idx,
                                  input logic [W-1:0] mid_val);
        @(negedge clk);
        start = 1; op = o; src_a = a; src_b = b; dst = d;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 0;
        check_output({name, "_busy"}, {31'd0, busy}, 32'd1);
        check_output({name, "_early_done"}, {31'd0, done}, 32'd0);
        if (mid_ld) begin
            drv_en = 1; drv = mid_val; ld = 1; ld_sel = mid_idx;
        end
        @(negedge clk);
        drv_en = 0; ld = 0;
        check_output({name, "_done"}, {31'd0, done}, 32'd1);
        wait_idle(name);
    endtask

    task automatic b_load(input logic [2:0] idx, input logic [W2-1:0] val);
        @(negedge clk);
        b_drv_en = 1; b_drv = val; b_ld = 1; b_ld_sel = idx;
        @(negedge clk);
        b_drv_en = 0; b_ld = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int tidx;
        time gap;

        // Reset state: outputs idle, bus floats even with eu and oe asserted.
        eu = 1; oe = 1;
        #12;
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_flags", {28'd0, cy, z, ng, gt}, 32'd0);
        check_output("rst_bus_z", {24'd0, w}, 32'hFF);
        eu = 0; oe = 0;
        @(negedge clk);
        clr = 1;

        load_reg(1, 8'h3C);
        read_reg("readback_r1", 1, 8'h3C);
        @(negedge clk);
        #1 check_output("bus_idle_z", {24'd0, w}, 32'hFF);

        load_reg(0, 8'hF0);
        load_reg(1, 8'h20);
        apply_stimulus("add_carry", OP_ADD, 0, 1, 2, 4'b1001, 0, 0, 0);
        read_reg("add_r2", 2, 8'h10);
        read_res("add_res", 8'h10);

        load_reg(0, 8'h05);
        load_reg(1, 8'h07);
        apply_stimulus("sub_borrow", OP_SUB, 0, 1, 3, 4'b1010, 0, 0, 0);
        read_reg("sub_r3", 3, 8'hFE);

        load_reg(0, 8'h07);
        apply_stimulus("cmp_equal", OP_CMP, 0, 1, 3, 4'b0100, 0, 0, 0);
        read_reg("cmp_r3_kept", 3, 8'hFE);
        read_res("cmp_res_kept", 8'hFE);

        // Source reload during EXEC must not disturb the latched operand.
        load_reg(0, 8'h80);
        apply_stimulus("pass", OP_PASS, 0, 1, 2, 4'b0011, 1, 0, 8'h11);
        read_reg("pass_r2", 2, 8'h80);
        read_reg("pass_r0_reload", 0, 8'h11);

        apply_stimulus("collide", OP_ADD, 0, 1, 3, 4'b0001, 1, 3, 8'hAA);
        read_reg("collide_r3", 3, 8'hAA);
        read_res("collide_res", 8'h18);

        // Start held for six edges: two operations, pulses three cycles apart.
        base = done_count;
        tidx = done_times.size();
        @(negedge clk);
        start = 1; op = OP_ADD; src_a = 0; src_b = 1; dst = 2;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        repeat (6) @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        check_output("held_ops", done_count - base, 32'd2);
        gap = (done_times.size() >= tidx + 2) ? done_times[tidx+1] - done_times[tidx] : 0;
        check_output("held_gap", 32'(gap), 32'd30);
        read_reg("held_r2", 2, 8'h18);

        // Reset while in EXEC aborts the operation.
        base = done_count;
        @(negedge clk);
        start = 1; op = OP_ADD; src_a = 0; src_b = 1; dst = 1;
        @(negedge clk);
        start = 0;
        clr = 0;
        eu = 1;
        #1;
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_done", {31'd0, done}, 32'd0);
        check_output("abort_flags", {28'd0, cy, z, ng, gt}, 32'd0);
        check_output("abort_bus_z", {24'd0, w}, 32'hFF);
        eu = 0;
        @(negedge clk);
        clr = 1;
        repeat (4) @(negedge clk);
        check_output("abort_no_done", done_count - base, 32'd0);
        for (int i = 0; i < 4; i++) read_reg("abort_reg_clear", 2'(i), 8'h00);
        read_res("abort_res_clear", 8'h00);

        // Wider instance: 0xFFFF + 1 wraps to zero with carry.
        b_load(0, 16'hFFFF);
        b_load(1, 16'h0001);
        @(negedge clk);
        b_start = 1; b_op = OP_ADD; b_src_a = 0; b_src_b = 1; b_dst = 7;
        @(negedge clk);
        b_start = 0;
        @(negedge clk);
        check_output("w16_done", {31'd0, b_done}, 32'd1);
        check_output("w16_flags", {28'd0, b_cy, b_z, b_ng, b_gt}, 32'b1101);
        @(negedge clk);
        b_oe = 1; b_oe_sel = 7;
        #1 check_output("w16_r7", {16'd0, b_w}, 32'h0000);
        b_oe = 0;
        @(negedge clk);

        check_output("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
